// File: rtl/seg_pkg.sv
// Shared segment glyph constants, PWM step count and the hex-to-segment decoder
// for the multiplexed 7-segment display driver.
package seg_pkg;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam int PWM_STEPS = 16;

  // Patterns are {g,f,e,d,c,b,a}, active-low for common-anode parts.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] pat;
    case (nibble)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_display_mux_if.sv
// Bus between score logic and the display driver; decimal-point signals exist
// only when SEG_DP_EN is defined.
interface seg_display_mux_if #(parameter int NUM_DIGITS = 4);

  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    load;
  logic                    blank_en;
  logic [3:0]              bright;
  logic                    disp_en;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
`ifdef SEG_DP_EN
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    dp;

  modport master (output digits_in, load, blank_en, bright, disp_en, dp_in,
                  input  seg, an, dp);
  modport slave  (input  digits_in, load, blank_en, bright, disp_en, dp_in,
                  output seg, an, dp);
`else
  modport master (output digits_in, load, blank_en, bright, disp_en,
                  input  seg, an);
  modport slave  (input  digits_in, load, blank_en, bright, disp_en,
                  output seg, an);
`endif

endinterface

// File: rtl/seg_scan_timer.sv
// Slot counter and digit index for the display scan; flags slot/frame wrap and
// whether the current cycle falls in the PWM on-phase of the slot.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [3:0]                    i_bright,
  output logic [$clog2(NUM_DIGITS)-1:0] o_idx,
  output logic                          o_slot_wrap,
  output logic                          o_frame_wrap,
  output logic                          o_on_phase
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV + 1);
  localparam int STEP  = REFRESH_DIV / PWM_STEPS;

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] w_thresh;

  // Threshold reaches REFRESH_DIV at bright=15, hence the extra counter bit.
  assign w_thresh     = CNT_W'((int'({1'b0, i_bright}) + 1) * STEP);
  assign o_on_phase   = (r_cnt < w_thresh);
  assign o_slot_wrap  = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign o_frame_wrap = o_slot_wrap && (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign o_idx        = r_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (o_slot_wrap) begin
      r_cnt <= '0;
      r_idx <= o_frame_wrap ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed 7-segment driver with PWM brightness, leading-zero blanking
// and tear-free double buffering. Define SEG_DP_EN to add decimal points.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input logic               clk,
  input logic               reset_n,
  seg_display_mux_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [NUM_DIGITS-1:0][3:0] r_shadow;
  logic [NUM_DIGITS-1:0][3:0] r_disp;
  logic                       r_pend;
  logic [6:0]                 r_seg;
  logic [NUM_DIGITS-1:0]      r_an;
  logic [IDX_W-1:0]           w_idx;
  logic                       w_slot_wrap;
  logic                       w_frame_wrap;
  logic                       w_on;
  logic [NUM_DIGITS-1:0]      w_blank;
  logic                       w_lit;
`ifdef SEG_DP_EN
  logic [NUM_DIGITS-1:0]      r_dp_shadow;
  logic [NUM_DIGITS-1:0]      r_dp_disp;
  logic                       r_dp;
`endif

  seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_bright     (bus.bright),
    .o_idx        (w_idx),
    .o_slot_wrap  (w_slot_wrap),
    .o_frame_wrap (w_frame_wrap),
    .o_on_phase   (w_on)
  );

  // A boundary load overwrites shadow but keeps pending, so it shows next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
      r_disp   <= '0;
      r_pend   <= 1'b0;
    end else begin
      if (w_frame_wrap && r_pend) begin
        r_disp <= r_shadow;
        r_pend <= 1'b0;
      end
      if (bus.load) begin
        r_shadow <= bus.digits_in;
        r_pend   <= 1'b1;
      end
    end
  end

`ifdef SEG_DP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dp_shadow <= '0;
      r_dp_disp   <= '0;
    end else begin
      if (w_frame_wrap && r_pend) r_dp_disp <= r_dp_shadow;
      if (bus.load)               r_dp_shadow <= bus.dp_in;
    end
  end
`endif

  // Walk from the top digit down; once a shown digit is met, nothing below is leading.
  always_comb begin
    logic v_keep;
    v_keep  = 1'b0;
    w_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
`ifdef SEG_DP_EN
      v_keep = v_keep | (|r_disp[k]) | r_dp_disp[k] | (k == 0);
`else
      v_keep = v_keep | (|r_disp[k]) | (k == 0);
`endif
      w_blank[k] = bus.blank_en & ~v_keep;
    end
  end

  assign w_lit = bus.disp_en & w_on & ~w_blank[w_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg <= SEG_OFF;
      r_an  <= '1;
    end else begin
      r_seg <= w_lit ? seg_decode(r_disp[w_idx]) : SEG_OFF;
      r_an  <= w_lit ? ~(NUM_DIGITS'(1) << w_idx) : '1;
    end
  end

`ifdef SEG_DP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_dp <= 1'b1;
    else          r_dp <= w_lit ? ~r_dp_disp[w_idx] : 1'b1;
  end
  assign bus.dp = r_dp;
`endif

  assign bus.seg = r_seg;
  assign bus.an  = r_an;

endmodule
